// File: rtl/fir_pkg.sv
// Shared types and helpers for the single-MAC FIR control path.
package fir_pkg;

    localparam int SAMPLE_W = 12;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        MAC,
        DRAIN,
        DONE
    } fir_state_t;

    // Total cycles from WRITE through DONE for one output sample.
    function automatic int pass_cycles(input int n, input int pipe_lat);
        return n + pipe_lat + 2;
    endfunction

endpackage

// File: rtl/fir_tap_counter.sv
// Tap address counter: restarts at 0 on start, sweeps 0..N-1 while enabled, then wraps to 0.
module fir_tap_counter #(
    parameter int ADDR_WIDTH = 8,
    parameter int N          = 251
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] count,
    output logic                  last
);

    logic [ADDR_WIDTH-1:0] count_reg;
    logic [ADDR_WIDTH-1:0] count_next;

    assign last  = (count_reg == ADDR_WIDTH'(N - 1));
    assign count = count_reg;

    // Wrapping on the final tap leaves the address at 0 between passes.
    always_comb begin
        count_next = count_reg;
        if (start) begin
            count_next = '0;
        end else if (en) begin
            count_next = last ? '0 : count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/fir_sequencer.sv
// Control FSM for a single-MAC FIR: buffers ADC samples, sweeps the taps,
// gates the accumulator through the pipeline delay and flags each finished output.
module fir_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int N          = 251,
    parameter int PIPE_LAT   = 2,
    parameter int SAMPLE_W   = fir_pkg::SAMPLE_W
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  sample_valid_in,
    input  logic [SAMPLE_W-1:0]   sample_in,
    input  logic                  ovr_clr_in,
    output logic                  wr_out,
    output logic [SAMPLE_W-1:0]   x_out,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  acc_clr_out,
    output logic                  acc_en_out,
    output logic                  y_valid_out,
    output logic                  busy_out,
    output logic                  overrun_out
);

    import fir_pkg::*;

    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    fir_state_t            state_reg, state_next;
    logic [SAMPLE_W-1:0]   hold_reg, hold_next;
    logic [SAMPLE_W-1:0]   pend_reg, pend_next;
    logic                  pend_valid_reg, pend_valid_next;
    logic                  overrun_reg, overrun_next;
    logic [DW-1:0]         drain_cnt_reg, drain_cnt_next;
    logic [PIPE_LAT-1:0]   tap_dly_reg;
    logic                  ovr_set;
    logic                  ctr_start;
    logic                  ctr_en;
    logic                  tap_valid;
    logic [ADDR_WIDTH-1:0] tap_count;
    logic                  tap_last;

    fir_tap_counter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .N          (N)
    ) u_tap_counter (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .start  (ctr_start),
        .en     (ctr_en),
        .count  (tap_count),
        .last   (tap_last)
    );

    always_comb begin
        state_next      = state_reg;
        hold_next       = hold_reg;
        pend_next       = pend_reg;
        pend_valid_next = pend_valid_reg;
        drain_cnt_next  = '0;
        ovr_set         = 1'b0;
        ctr_start       = 1'b0;
        ctr_en          = 1'b0;
        wr_out          = 1'b0;
        acc_clr_out     = 1'b0;
        y_valid_out     = 1'b0;

        case (state_reg)
            IDLE: begin
                // A waiting sample goes first; a coincident strobe refills pending.
                if (pend_valid_reg) begin
                    hold_next  = pend_reg;
                    state_next = WRITE;
                    if (sample_valid_in) begin
                        pend_next = sample_in;
                    end else begin
                        pend_valid_next = 1'b0;
                    end
                end else if (sample_valid_in) begin
                    hold_next  = sample_in;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                wr_out      = 1'b1;
                acc_clr_out = 1'b1;
                ctr_start   = 1'b1;
                state_next  = MAC;
            end
            MAC: begin
                ctr_en = 1'b1;
                if (tap_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt_reg == DW'(PIPE_LAT - 1)) begin
                    state_next = DONE;
                end else begin
                    drain_cnt_next = drain_cnt_reg + 1'b1;
                end
            end
            DONE: begin
                y_valid_out = 1'b1;
                if (pend_valid_reg) begin
                    hold_next       = pend_reg;
                    pend_valid_next = 1'b0;
                    state_next      = WRITE;
                end else if (sample_valid_in) begin
                    hold_next  = sample_in;
                    state_next = WRITE;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Strobes arriving mid-pass park in pending or are dropped if it is full.
        if (sample_valid_in && (state_reg inside {WRITE, MAC, DRAIN})) begin
            if (!pend_valid_reg) begin
                pend_next       = sample_in;
                pend_valid_next = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end
        if (sample_valid_in && (state_reg == DONE) && pend_valid_reg) begin
            ovr_set = 1'b1;
        end

        overrun_next = overrun_reg;
        if (ovr_set) begin
            overrun_next = 1'b1;
        end else if (ovr_clr_in) begin
            overrun_next = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_reg      <= IDLE;
            hold_reg       <= '0;
            pend_reg       <= '0;
            pend_valid_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            drain_cnt_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            hold_reg       <= hold_next;
            pend_reg       <= pend_next;
            pend_valid_reg <= pend_valid_next;
            overrun_reg    <= overrun_next;
            drain_cnt_reg  <= drain_cnt_next;
        end
    end

    // Tap-valid delayed to line up with the product reaching the accumulator.
    assign tap_valid = (state_reg == MAC);

    for (genvar gi = 0; gi < PIPE_LAT; gi++) begin : g_tap_dly
        always_ff @(posedge clk_in) begin
            if (!rst_in) begin
                tap_dly_reg[gi] <= 1'b0;
            end else if (gi == 0) begin
                tap_dly_reg[gi] <= tap_valid;
            end else begin
                tap_dly_reg[gi] <= tap_dly_reg[(gi == 0) ? 0 : gi - 1];
            end
        end
    end

    assign acc_en_out  = tap_dly_reg[PIPE_LAT-1];
    assign addr_out    = (state_reg == MAC) ? tap_count : '0;
    assign x_out       = wr_out ? hold_reg : '0;
    assign busy_out    = (state_reg != IDLE);
    assign overrun_out = overrun_reg;

endmodule

// File: doc/fir_sequencer.md
Name: fir_sequencer

Overview:
- Control FSM for the single-MAC FIR datapath (coefficient ROM, sample buffer, accumulator).
- Accepts ADC sample strobes and writes each sample into the data buffer.
- Sweeps the tap address through N taps while gating the accumulator, then flags the output valid.
- Decouples ADC timing from the MAC pass with a one-deep pending-sample register and a sticky overrun flag.

Parameters:
ADDR_WIDTH, 8, width of tap address; N must be <= 2**ADDR_WIDTH
N, 251, number of filter taps; N >= 2
PIPE_LAT, 2, cycles from addr_out to matching product at accumulator input (ROM/buffer read + multiply register); PIPE_LAT >= 1
SAMPLE_W, 12, ADC sample width

Ports:
clk_in  in  1  single clock
rst_in  in  1  synchronous, active-low reset
sample_valid_in  in  1  one-cycle strobe: sample_in valid
sample_in  in  SAMPLE_W  ADC sample
ovr_clr_in  in  1  clears overrun_out
wr_out  out  1  write strobe to data buffer
x_out  out  SAMPLE_W  sample presented to data buffer, valid when wr_out=1
addr_out  out  ADDR_WIDTH  tap index to coefficient ROM and data buffer
acc_clr_out  out  1  clears accumulator
acc_en_out  out  1  accumulate current product
y_valid_out  out  1  one-cycle pulse: accumulator holds a finished output
busy_out  out  1  high in every state except IDLE
overrun_out  out  1  sticky: a sample was dropped

Behaviour:
- Reset (rst_in=0 at a clk_in edge): state=IDLE, pending empty, holding reg=0, overrun_out=0. All outputs 0, addr_out=0.
- Reset mid-pass aborts the pass with no y_valid_out pulse and discards any pending sample.
- States: IDLE, WRITE, MAC, DRAIN, DONE.
- IDLE: on sample_valid_in, capture sample_in into holding reg and go to WRITE. If pending is full, load it into holding reg and go to WRITE. Pending takes priority; a simultaneous new strobe then goes to pending.
- WRITE (1 cycle): wr_out=1, x_out=holding reg, acc_clr_out=1, addr_out=0. Next state MAC.
- MAC (N cycles): addr_out counts 0..N-1, incrementing by 1 each cycle. Leaves to DRAIN after addr_out=N-1. addr_out returns to 0 outside MAC.
- acc_en_out: tap-valid bit (1 during MAC) delayed by PIPE_LAT registers. Exactly N acc_en_out cycles per pass, the first PIPE_LAT cycles after MAC entry.
- DRAIN (PIPE_LAT cycles): shift register flushes. Next state DONE.
- DONE (1 cycle): y_valid_out=1. Go to WRITE if pending (or a strobe this cycle) is available, else IDLE.
- Pass length: N+PIPE_LAT+2 cycles.
- Latency: strobe in IDLE at cycle t gives WRITE at t+1 and y_valid_out at t+N+PIPE_LAT+2 (t+255 at defaults).
- Sustained rate: one sample per N+PIPE_LAT+2 cycles.
- Strobe while busy_out=1:
  - pending empty: sample stored in pending.
  - pending full: sample dropped, pending unchanged, overrun_out set.
  - A strobe in DONE follows the same rule; pending is consumed in the following WRITE.
- ovr_clr_in clears overrun_out next cycle. A simultaneous set wins.
- acc_clr_out and acc_en_out are never high in the same cycle.
- wr_out is never high outside WRITE.

Decomposition:
- Package fir_pkg holds:
  - state enum fir_state_t {IDLE, WRITE, MAC, DRAIN, DONE}
  - SAMPLE_W constant
  - function pass_cycles(N, PIPE_LAT) returning N+PIPE_LAT+2
- One sub-module: fir_tap_counter (ADDR_WIDTH, N).
  - Inputs: start, en.
  - Outputs: count, last (count==N-1).
  - Synchronous active-low rst_in.
- The FSM, pending register, overrun flag and PIPE_LAT delay line live in fir_sequencer.

Test Plan:
- Single strobe at cycle 10 with sample_in=0x5A3, N=251, PIPE_LAT=2 -> checks:
  - wr_out at 11 with x_out=0x5A3, acc_clr_out at 11
  - addr_out 0..250 on cycles 12..262
  - acc_en_out high on cycles 14..264 (251 cycles)
  - y_valid_out only at 265; busy_out low from 266
- Small config N=4, PIPE_LAT=1, strobe every 7 cycles (= pass length) -> every pass completes, no overrun, y_valid_out period 7, pending never used.
- N=4, PIPE_LAT=1: second strobe mid-MAC with 0x111 -> held in pending; DONE goes straight to WRITE with x_out=0x111; overrun_out stays 0.
- N=4, PIPE_LAT=1: three strobes within one pass (0x001, 0x002, 0x003) -> 0x002 processed next, 0x003 dropped, overrun_out=1. ovr_clr_in pulse clears it; ovr_clr_in together with a new drop leaves overrun_out=1.
- rst_in=0 for one cycle in mid-MAC with pending full -> next cycle all outputs 0, addr_out=0, state IDLE. No y_valid_out for the aborted pass; the pending sample is not written.
- Strobe in the exact DONE cycle, pending empty -> WRITE on the next cycle with that sample; y_valid_out pulses exactly once per pass.
